// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor.
// The datapath is built from 4-bit lookahead groups. Each of the NS register stages
// resolves GPS groups and passes its carry-out into the next stage.
// Optional flags: define CLA_PIPE_FLAGS_EN to build registered ovf/zero outputs.
// When it is undefined, ovf and zero are tied to 0.
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int GPS   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int NS = WIDTH / (4 * GPS);
    // Operand registers only exist between stages; the last stage needs no operands after it.
    localparam int NA = (NS > 1) ? NS - 1 : 1;

    // Full 4-bit lookahead off the group carry-in, with OR-propagate. Bits [3:0] are the
    // carries into each bit. Bit [4] is the group carry-out.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] g, p;
        logic [4:0] c;
        g    = x & y;
        p    = x | y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    // One stage: the group carry ripples through groups k*GPS .. k*GPS+GPS-1.
    // The result is returned as {carry_out, partial_sum}.
    function automatic logic [WIDTH:0] stage_fn(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                input logic [WIDTH-1:0] s, input logic c, input int k);
        logic [4:0] cc;
        int         base;
        for (int g = 0; g < GPS; g++) begin
            base         = (k * GPS + g) * 4;
            cc           = cla4(x[base +: 4], y[base +: 4], c);
            s[base +: 4] = x[base +: 4] ^ y[base +: 4] ^ cc[3:0];
            c            = cc[4];
        end
        return {c, s};
    endfunction

    logic             adv;
    logic [NS:1]      vld_pipe;
    logic [WIDTH-1:0] pa [0:NA-1];
    logic [WIDTH-1:0] pb [0:NA-1];
    logic [WIDTH-1:0] ps [1:NS];
    logic [NS:1]      pc;

    // Per-stage input view. Index 0 is the conditioned pipeline input.
    logic [WIDTH-1:0] sva [0:NS-1];
    logic [WIDTH-1:0] svb [0:NS-1];
    logic [WIDTH-1:0] svs [0:NS-1];
    logic [NS-1:0]    svc;
    logic [WIDTH-1:0] nxs [0:NS-1];
    logic [NS-1:0]    nxc;

    // The whole pipe moves in lockstep. It stalls only when a result is waiting and is refused.
    assign adv       = ~vld_pipe[NS] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[NS];
    assign sum       = ps[NS];
    assign co        = pc[NS];

    // Build each stage's operands and evaluate its lookahead groups.
    // Subtraction is done as a + ~b + 1 before stage 0.
    always_comb begin
        sva[0] = a;
        svb[0] = sub ? ~b : b;
        svs[0] = '0;
        svc[0] = sub | ci;
        for (int k = 1; k < NS; k++) begin
            sva[k] = pa[k-1];
            svb[k] = pb[k-1];
            svs[k] = ps[k];
            svc[k] = pc[k];
        end
        for (int k = 0; k < NS; k++) begin
            {nxc[k], nxs[k]} = stage_fn(sva[k], svb[k], svs[k], svc[k], k);
        end
    end

    // Stage registers: the valid shift register, partial sums, inter-stage carries and operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            pc       <= '0;
            for (int k = 1; k <= NS; k++) ps[k] <= '0;
            for (int j = 0; j < NA; j++) begin
                pa[j] <= '0;
                pb[j] <= '0;
            end
        end else if (adv) begin
            vld_pipe[1] <= in_valid;
            for (int k = 2; k <= NS; k++) vld_pipe[k] <= vld_pipe[k-1];
            for (int k = 0; k < NS; k++) begin
                ps[k+1] <= nxs[k];
                pc[k+1] <= nxc[k];
            end
            for (int k = 0; k < NS - 1; k++) begin
                pa[k] <= sva[k];
                pb[k] <= svb[k];
            end
        end
    end

`ifdef CLA_PIPE_FLAGS_EN
    logic ovf_q, zero_q;

    // Flags are registered alongside the last stage. The carry into the MSB is
    // recovered as a^b^sum at the MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            ovf_q  <= nxc[NS-1] ^ (nxs[NS-1][WIDTH-1] ^ sva[NS-1][WIDTH-1] ^ svb[NS-1][WIDTH-1]);
            zero_q <= ~|nxs[NS-1];
        end
    end

    assign ovf  = ovf_q;
    assign zero = zero_q;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder. A 16-bit/GPS=1 instance carries the main traffic.
// A 32-bit/GPS=2 instance covers the wide carry-through case.
module tb_cla_pipe_adder;

    localparam int W  = 16;
    localparam int NS = 4;
`ifdef CLA_PIPE_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf, zero;
    logic [W-1:0] a, b, sum;

    logic         in_valid32, in_ready32, out_valid32, co32, ovf32, zero32;
    logic [31:0]  a32, b32, sum32;

    cla_pipe_adder #(.WIDTH(W), .GPS(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .co(co), .ovf(ovf), .zero(zero)
    );

    cla_pipe_adder #(.WIDTH(32), .GPS(2)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .ci(1'b1), .sub(1'b0), .out_valid(out_valid32), .out_ready(1'b1),
        .sum(sum32), .co(co32), .ovf(ovf32), .zero(zero32)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
        logic         zero;
    } res_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sub;
        res_t         e;
    } vec_t;

    res_t sb_q[$];
    vec_t vt[15];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            res_t got, e;
            got = {sum, co, ovf, zero};
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %0h with empty scoreboard", got);
            end else begin
                e = sb_q.pop_front();
                chk("result{sum,co,ovf,zero}", got, e);
            end
        end
    end

    // Present one operation and hold it until the DUT takes it. The expectation is
    // pushed on the cycle it is accepted. Returns just after the accepting edge.
    task automatic send(input vec_t v, output int waited);
        res_t m;
        a = v.a; b = v.b; ci = v.ci; sub = v.sub; in_valid = 1'b1;
        waited = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) begin
                m = v.e;
                if (!FLAGS) begin
                    m.ovf  = 1'b0;
                    m.zero = 1'b0;
                end
                sb_q.push_back(m);
                @(posedge clk); #1;
                break;
            end
            waited++;
            if (waited > 100) begin
                total++;
                bad++;
                $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", waited);
                @(posedge clk); #1;
                break;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", sb_q.size(), 0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        //             a         b        ci    sub   sum       co    ovf   zero
        vt[0]  = {16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[1]  = {16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vt[2]  = {16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vt[3]  = {16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vt[4]  = {16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[5]  = {16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vt[6]  = {16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b0};
        vt[7]  = {16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vt[8]  = {16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
        vt[9]  = {16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vt[10] = {16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vt[11] = {16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[12] = {16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0};
        vt[13] = {16'hFFFE, 16'h0001, 1'b0, 1'b1, 16'hFFFD, 1'b1, 1'b0, 1'b0};
        vt[14] = {16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};

        in_valid = 0; a = '0; b = '0; ci = 0; sub = 0; out_ready = 1;
        in_valid32 = 0; a32 = '0; b32 = '0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_co", co, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_zero", zero, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // First op: out_valid rises on the NS-th edge, counting the accepting edge
        send(vt[0], w);
        in_valid = 0;
        for (int c = 1; c < NS; c++) begin
            @(negedge clk);
            chk("latency_early_valid", out_valid, 0);
        end
        @(negedge clk);
        chk("latency_valid", out_valid, 1);
        @(posedge clk); #1;
        drain();

        // Subtract and signed overflow
        send(vt[1], w);
        send(vt[2], w);
        in_valid = 0;
        drain();

        // Eight back-to-back ops: the DUT never pushes back
        for (int i = 3; i <= 10; i++) begin
            send(vt[i], w);
            chk("b2b_wait_cycles", w, 0);
        end
        in_valid = 0;
        drain();

        // Fill with out_ready low, hold for 10 cycles, then release
        out_ready = 0;
        for (int i = 11; i <= 14; i++) send(vt[i], w);
        in_valid = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_sum_held", sum, sb_q[0].sum);
        end
        @(posedge clk); #1;
        out_ready = 1;
        drain();

        // Mid-stream reset with three ops in flight and an op offered during reset
        for (int i = 0; i < 3; i++) send(vt[i], w);
        a = 16'h1111; b = 16'h2222; ci = 0; sub = 0; in_valid = 1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        in_valid = 0;
        sb_q.delete();
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_co", co, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_zero", zero, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("no_stale_out", out_valid, 0);
        end
        @(posedge clk); #1;

        // 32-bit, GPS=2: carry runs through every stage
        a32 = 32'hFFFF_FFFF; b32 = 32'h0; in_valid32 = 1;
        @(negedge clk);
        chk("w32_in_ready", in_ready32, 1);
        @(posedge clk); #1;
        in_valid32 = 0;
        for (int c = 1; c < NS; c++) begin
            @(negedge clk);
            chk("w32_early_valid", out_valid32, 0);
        end
        @(negedge clk);
        chk("w32_out_valid", out_valid32, 1);
        chk("w32_sum", sum32, 32'h0);
        chk("w32_co", co32, 1);
        chk("w32_zero", zero32, FLAGS);
        chk("w32_ovf", ovf32, 0);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
